capture_ctrl: RTL and testbench

Parametrised multi-channel acquisition engine for the DSO digital core. Generates the ADC sample clock, writes `NUM_CH` ADC streams into circular sample buffers, and applies a selectable trigger source and polarity, a programmable post-trigger depth and sample decimation. Once a capture completes, it serves trigger-relative readback to the command/UART path. It supersedes the fixed three-channel, 512-deep, ungated RAM hookup.

---
 rtl/dso_pkg.sv | 27 ++
 rtl/sample_ram.sv | 35 +++
 rtl/capture_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared definitions for the DSO capture path.
// Contents:
//   Def*            default widths for capture_ctrl parameters
//   St*             capture FSM state encodings
//   TrigSrc*        trig_src encodings for the two comparator inputs
//   trig_is_auto()  true for the immediate-trigger encodings (2 and 3)
package dso_pkg;

  localparam int unsigned DefNumCh = 3;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 9;
  localparam int unsigned DefDecW  = 4;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StArmed = 3'd2;
  localparam logic [2:0] StPost  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [1:0] TrigSrc1 = 2'd0;
  localparam logic [1:0] TrigSrc2 = 2'd1;

  function automatic logic trig_is_auto(logic [1:0] src);
    return src[1];
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port synchronous sample RAM, one per ADC channel.
// Ports:
//   clk, rst_n  clock and async active-low reset (read register only)
//   en, we      access enable; we=1 writes, we=0 reads
//   addr        shared buffer address
//   wdata       sample to store
//   rdata       registered read data, valid the cycle after a read
module sample_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Multi-channel acquisition engine: ADC clock generation, decimated circular capture into
// per-channel RAMs, trigger source/polarity selection, post-trigger depth and
// trigger-relative readback once the capture is done.
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   adc_clk              ADC clock (clk/2)
//   ch_data              NUM_CH packed ADC samples, channel 0 in LSBs
//   trig1, trig2         asynchronous comparator inputs
//   start                one-cycle pulse: latch config and (re)start capture
//   trig_src/pol/pos     trigger source, polarity, samples stored after trigger
//   dec                  keep one sample in every dec+1 strobes
//   busy, done           capture in progress / complete
//   trig_addr            buffer address of the trigger sample
//   rd_en/ch/offset      readback request, offset 0 = oldest sample
//   rd_data, rd_vld      readback result, one cycle after rd_en
module capture_ctrl
  import dso_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEC_W  = DefDecW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       adc_clk,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       trig1,
  input  logic                       trig2,
  input  logic                       start,
  input  logic [1:0]                 trig_src,
  input  logic                       trig_pol,
  input  logic [ADDR_W-1:0]          trig_pos,
  input  logic [DEC_W-1:0]           dec,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          trig_addr,
  input  logic                       rd_en,
  input  logic [$clog2(NUM_CH)-1:0]  rd_ch,
  input  logic [ADDR_W-1:0]          rd_offset,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_vld
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic              adc_clk_q;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic              trig_pend_q, trig_pend_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [1:0]        src_q, src_d;
  logic              pol_q, pol_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [1:0]        sync1_q, sync2_q;
  logic              sel_prev_q;
  logic              rd_vld_q;
  logic [CH_W-1:0]   rd_ch_q;

  logic              capturing, strobe, wr_en, rd_acc, sel_sync, trig_edge;
  logic [ADDR_W-1:0] rd_addr, ram_addr;
  logic [DATA_W-1:0] ram_rdata [NUM_CH];

  assign strobe    = adc_clk_q;
  assign capturing = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
  // A start pulse pre-empts any write in the same cycle.
  assign wr_en     = capturing && strobe && (dec_cnt_q == '0) && !start;
  assign rd_acc    = (state_q == StDone) && rd_en && !start;
  assign cnt_inc   = cnt_q + ADDR_W'(1);
  // Oldest sample sits just after the last POST write.
  assign rd_addr   = trig_addr_q + pos_q + rd_offset + ADDR_W'(1);
  assign ram_addr  = (state_q == StDone) ? rd_addr : wr_ptr_q;

  always_comb begin
    case (src_q)
      TrigSrc1: sel_sync = sync2_q[0];
      TrigSrc2: sel_sync = sync2_q[1];
      default:  sel_sync = 1'b0;
    endcase
  end

  assign trig_edge = pol_q ? (sel_prev_q & ~sel_sync) : (sel_sync & ~sel_prev_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    dec_cnt_d   = dec_cnt_q;
    trig_pend_d = trig_pend_q;
    trig_addr_d = trig_addr_q;
    src_d       = src_q;
    pol_d       = pol_q;
    pos_d       = pos_q;
    dec_d       = dec_q;
    if (start) begin
      src_d       = trig_src;
      pol_d       = trig_pol;
      // An ADDR_W-bit trig_pos can never exceed DEPTH-1, so the clamp is implicit.
      pos_d       = trig_pos;
      dec_d       = dec;
      dec_cnt_d   = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      trig_pend_d = 1'b0;
      // Pre-trigger length is DEPTH-1-trig_pos == ~trig_pos; zero skips PRE.
      state_d     = (trig_pos == '1) ? StArmed : StPre;
    end else begin
      if (capturing && strobe) begin
        dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + DEC_W'(1);
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (trig_edge) trig_pend_d = 1'b1;
      case (state_q)
        StPre: begin
          trig_pend_d = 1'b0;
          if (wr_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == ~pos_q) begin
              state_d = StArmed;
              cnt_d   = '0;
            end
          end
        end
        StArmed: begin
          if (wr_en && (trig_pend_q || trig_is_auto(src_q))) begin
            trig_addr_d = wr_ptr_q;
            trig_pend_d = 1'b0;
            state_d     = (pos_q == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (wr_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pos_q) begin
              state_d = StDone;
              cnt_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_clk_q   <= 1'b0;
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      dec_cnt_q   <= '0;
      trig_pend_q <= 1'b0;
      trig_addr_q <= '0;
      src_q       <= '0;
      pol_q       <= 1'b0;
      pos_q       <= '0;
      dec_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sel_prev_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_ch_q     <= '0;
    end else begin
      adc_clk_q   <= ~adc_clk_q;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      trig_pend_q <= trig_pend_d;
      trig_addr_q <= trig_addr_d;
      src_q       <= src_d;
      pol_q       <= pol_d;
      pos_q       <= pos_d;
      dec_q       <= dec_d;
      sync1_q     <= {trig2, trig1};
      sync2_q     <= sync1_q;
      sel_prev_q  <= sel_sync;
      rd_vld_q    <= rd_acc;
      if (rd_acc) rd_ch_q <= rd_ch;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ram
    sample_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en | rd_acc),
      .we    (wr_en),
      .addr  (ram_addr),
      .wdata (ch_data[c*DATA_W +: DATA_W]),
      .rdata (ram_rdata[c])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_q == CH_W'(c)) rd_data = ram_rdata[c];
    end
  end

  assign adc_clk   = adc_clk_q;
  assign busy      = capturing;
  assign done      = (state_q == StDone);
  assign trig_addr = trig_addr_q;
  assign rd_vld    = rd_vld_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: table of auto-trigger captures plus hand-written
// sequences for comparator triggers, polarity, abort, read gating and reset.
module tb_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_clk;
  logic [23:0] ch_data;
  logic        trig1 = 1'b0;
  logic        trig2 = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  trig_src = 2'd0;
  logic        trig_pol = 1'b0;
  logic [8:0]  trig_pos = 9'd0;
  logic [3:0]  dec = 4'd0;
  logic        busy, done;
  logic [8:0]  trig_addr;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_ch = 2'd0;
  logic [8:0]  rd_offset = 9'd0;
  logic [7:0]  rd_data;
  logic        rd_vld;

  int n_cmp = 0;
  int n_err = 0;

  capture_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_clk   (adc_clk),
    .ch_data   (ch_data),
    .trig1     (trig1),
    .trig2     (trig2),
    .start     (start),
    .trig_src  (trig_src),
    .trig_pol  (trig_pol),
    .trig_pos  (trig_pos),
    .dec       (dec),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .rd_en     (rd_en),
    .rd_ch     (rd_ch),
    .rd_offset (rd_offset),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld)
  );

  always #5 clk = ~clk;

  // ADC model: a new ramp sample on every adc_clk rise; channel c is offset by 37*c.
  logic [7:0] adc_idx = 8'd0;
  always @(posedge adc_clk) adc_idx <= adc_idx + 8'd1;
  assign ch_data = {adc_idx + 8'd74, adc_idx + 8'd37, adc_idx};

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic kick(input logic [1:0] src, input logic pol, input logic [8:0] pos,
                      input logic [3:0] d);
    trig_src = src;
    trig_pol = pol;
    trig_pos = pos;
    dec      = d;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", int'(done), 1);
  endtask

  task automatic rd(input int ch, input int off, output int d, output int v);
    logic [1:0] ch_b;
    logic [8:0] off_b;
    ch_b      = ch[1:0];
    off_b     = off[8:0];
    rd_en     = 1'b1;
    rd_ch     = ch_b;
    rd_offset = off_b;
    @(negedge clk);
    d     = int'(rd_data);
    v     = int'(rd_vld);
    rd_en = 1'b0;
  endtask

  // Drive a trigger pin and predict the sample taken: pend after 3 clk, then the next
  // strobe (dec=0) writes the sample currently on ch0.
  task automatic fire(input int which, input logic val, output int exp_v);
    if (which == 1) trig1 = val;
    else            trig2 = val;
    repeat (3) @(posedge clk);
    exp_v = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (adc_clk) begin
        exp_v = int'(ch_data[7:0]);
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] src;
    logic [8:0] pos;
    logic [3:0] dec;
    int         exp_ta;
    int         off;
    int         exp_diff;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, d0, dk, d1, v, w, ev;

    vecs[0] = '{2'd2, 9'd256, 4'd0, 255, 255, 255};
    vecs[1] = '{2'd3, 9'd0,   4'd0, 511, 511, 255};
    vecs[2] = '{2'd2, 9'd511, 4'd0, 0,   100, 100};
    vecs[3] = '{2'd2, 9'd256, 4'd3, 255, 10,  40};
    vecs[4] = '{2'd3, 9'd100, 4'd1, 411, 1,   2};

    // Reset state
    #1;
    chk("rst_adc_clk", int'(adc_clk), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trig_addr", int'(trig_addr), 0);
    chk("rst_rd_vld", int'(rd_vld), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    rd(0, 0, d0, v);
    chk("idle_rd_vld", v, 0);

    // Auto-trigger captures: length, trigger address, data ordering, channel packing
    for (int i = 0; i < 5; i++) begin
      w = 2 * (int'(vecs[i].dec) + 1);
      kick(vecs[i].src, 1'b0, vecs[i].pos, vecs[i].dec);
      chk($sformatf("busy_after_start[%0d]", i), int'(busy), 1);
      wait_done(511 * w + 50, cyc);
      chk_range($sformatf("cap_len[%0d]", i), cyc, 511 * w + 1, 511 * w + 4);
      chk($sformatf("busy_at_done[%0d]", i), int'(busy), 0);
      chk($sformatf("trig_addr[%0d]", i), int'(trig_addr), vecs[i].exp_ta);
      rd(0, 0, d0, v);
      rd(0, vecs[i].off, dk, v);
      chk($sformatf("rd_vld[%0d]", i), v, 1);
      chk($sformatf("data_diff[%0d]", i), (dk - d0) & 255, vecs[i].exp_diff);
      rd(1, vecs[i].off, d1, v);
      chk($sformatf("ch1_offset[%0d]", i), (d1 - dk) & 255, 37);
    end

    // trig1 rising, pulse during PRE must be ignored
    kick(2'd0, 1'b0, 9'd50, 4'd0);
    repeat (100) @(negedge clk);
    trig1 = 1'b1;
    repeat (10) @(negedge clk);
    trig1 = 1'b0;
    repeat (990) @(negedge clk);
    chk("pre_edge_ignored_done", int'(done), 0);
    chk("pre_edge_ignored_busy", int'(busy), 1);
    fire(1, 1'b1, ev);
    wait_done(300, cyc);
    rd(0, 461, dk, v);
    chk("trig1_sample", dk, ev);
    rd(0, 460, dk, v);
    chk("trig1_prev_sample", dk, (ev - 1) & 255);
    rd(1, 461, d1, v);
    chk("trig1_ch1", d1, (ev + 37) & 255);
    trig1 = 1'b0;

    // trig2 falling: rising edge must not trigger; read in ARMED is ignored
    kick(2'd1, 1'b1, 9'd20, 4'd0);
    repeat (1100) @(negedge clk);
    rd(0, 0, d0, v);
    chk("armed_rd_vld", v, 0);
    trig2 = 1'b1;
    repeat (100) @(negedge clk);
    chk("rise_ignored_done", int'(done), 0);
    fire(2, 1'b0, ev);
    wait_done(200, cyc);
    rd(0, 491, dk, v);
    chk("trig2_fall_sample", dk, ev);

    // Abort during POST, restart with new config
    kick(2'd2, 1'b0, 9'd256, 4'd3);
    repeat (3000) @(negedge clk);
    chk("post_busy", int'(busy), 1);
    chk("post_done", int'(done), 0);
    kick(2'd2, 1'b0, 9'd256, 4'd0);
    repeat (10) @(negedge clk);
    chk("abort_done_low", int'(done), 0);
    chk("abort_busy", int'(busy), 1);
    wait_done(1100, cyc);
    chk_range("abort_cap_len", cyc, 1012, 1016);
    chk("abort_trig_addr", int'(trig_addr), 255);
    rd(2, 255, dk, v);
    rd(0, 255, d0, v);
    chk("ch2_offset", (dk - d0) & 255, 74);

    // start and rd_en together: start wins
    trig_src = 2'd2;
    trig_pos = 9'd256;
    dec      = 4'd0;
    start    = 1'b1;
    rd_en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_en = 1'b0;
    chk("start_wins_rd_vld", int'(rd_vld), 0);
    chk("start_wins_done", int'(done), 0);
    chk("start_wins_busy", int'(busy), 1);

    // Asynchronous reset mid-capture
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_adc_clk", int'(adc_clk), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_trig_addr", int'(trig_addr), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_rd_vld", int'(rd_vld), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
